// File: rtl/insn_enc_pkg.sv
// Shared opcodes, layer codes and field positions for the instruction encoder and decoder.
// CV sequence length depends on INSN_ENC_SELPE_EN (CVSELPE insertion).
package insn_enc_pkg;

  localparam logic [4:0] OP_CFGL    = 5'd1;
  localparam logic [4:0] OP_CFGFC   = 5'd2;
  localparam logic [4:0] OP_CFGCV   = 5'd3;
  localparam logic [4:0] OP_CFGCVIF = 5'd4;
  localparam logic [4:0] OP_FCLIF   = 5'd5;
  localparam logic [4:0] OP_FCLW    = 5'd6;
  localparam logic [4:0] OP_FCSOF   = 5'd7;
  localparam logic [4:0] OP_CVAIF   = 5'd8;
  localparam logic [4:0] OP_CVAW    = 5'd9;
  localparam logic [4:0] OP_CVAOF   = 5'd10;
  localparam logic [4:0] OP_CVLIFP  = 5'd11;
  localparam logic [4:0] OP_CVLWP   = 5'd12;
  localparam logic [4:0] OP_CVSOFP  = 5'd13;
  localparam logic [4:0] OP_MPAIF   = 5'd14;
  localparam logic [4:0] OP_MPSOF   = 5'd15;
  localparam logic [4:0] OP_CVSELPE = 5'd16;
  localparam logic [4:0] OP_EOC     = 5'd31;

  localparam logic [4:0] LAYER_FC = 5'd1;
  localparam logic [4:0] LAYER_CV = 5'd2;
  localparam logic [4:0] LAYER_MP = 5'd3;

  // Field positions inside the 27-bit payload; the decoder uses the same values.
  localparam int OP_LSB          = 27;
  localparam int CFGL_TYPE_LSB   = 16;
  localparam int CFGL_ACT_LSB    = 5;
  localparam int CFGL_BIAS_BIT   = 0;
  localparam int CFG_CIN_LSB     = 16;
  localparam int CFG_COUT_LSB    = 5;
  localparam int CFG_K_LSB       = 0;
  localparam int CFGCVIF_H_LSB   = 13;
  localparam int CFGCVIF_W_LSB   = 0;
  localparam int SELPE_BCAST_BIT = 8;

`ifdef INSN_ENC_SELPE_EN
  localparam logic [3:0] CV_WORDS = 4'd10;
`else
  localparam logic [3:0] CV_WORDS = 4'd9;
`endif

  typedef struct packed {
    logic [4:0]  typ;
    logic [4:0]  act;
    logic        bias;
    logic        last;
    logic [10:0] cin;
    logic [10:0] cout;
    logic [4:0]  k;
    logic [12:0] h;
    logic [12:0] w;
    logic [26:0] ifaddr;
    logic [26:0] weaddr;
    logic [26:0] ofaddr;
  } desc_t;

  localparam int DESC_W = $bits(desc_t);

  function automatic logic [3:0] layer_words(input logic [4:0] typ);
    case (typ)
      LAYER_FC: return 4'd5;
      LAYER_CV: return CV_WORDS;
      LAYER_MP: return 4'd3;
      default:  return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] mk_word(input logic [4:0] op, input logic [26:0] pl);
    return {op, pl};
  endfunction

endpackage

// File: rtl/insn_encoder_insn_word_rom.sv
// Combinational word table: instruction word and last-word flag for a descriptor and word index.
// Honours INSN_ENC_SELPE_EN (CVSELPE before CVLIFP).
module insn_word_rom
  import insn_enc_pkg::*;
(
  input  logic [DESC_W-1:0] desc_i,
  input  logic [3:0]        idx,
  output logic [31:0]       word,
  output logic              is_last,
  output logic              empty
);

  desc_t       desc;
  logic [4:0]  op;
  logic [26:0] pl;
  logic [3:0]  n_layer;
  logic [4:0]  n_total;
  logic [26:0] cfgl_pl;
  logic [26:0] io_pl;
  logic [26:0] cvif_pl;

  assign desc    = desc_t'(desc_i);
  assign cfgl_pl = (27'(desc.typ) << CFGL_TYPE_LSB) | (27'(desc.act) << CFGL_ACT_LSB)
                 | (27'(desc.bias) << CFGL_BIAS_BIT);
  assign io_pl   = (27'(desc.cin) << CFG_CIN_LSB) | (27'(desc.cout) << CFG_COUT_LSB);
  assign cvif_pl = (27'(desc.h) << CFGCVIF_H_LSB) | (27'(desc.w) << CFGCVIF_W_LSB);

  always_comb begin
    op      = '0;
    pl      = '0;
    n_layer = layer_words(desc.typ);
    n_total = {1'b0, n_layer} + {4'd0, desc.last};
    if (idx < n_layer) begin
      if (idx == 4'd0) begin
        op = OP_CFGL;
        pl = cfgl_pl;
      end else begin
        case (desc.typ)
          LAYER_FC: begin
            case (idx)
              4'd1: begin op = OP_CFGFC; pl = io_pl;       end
              4'd2: begin op = OP_FCLIF; pl = desc.ifaddr; end
              4'd3: begin op = OP_FCLW;  pl = desc.weaddr; end
              4'd4: begin op = OP_FCSOF; pl = desc.ofaddr; end
              default: ;
            endcase
          end
          LAYER_CV: begin
            case (idx)
              4'd1: begin op = OP_CFGCV;   pl = io_pl | (27'(desc.k) << CFG_K_LSB); end
              4'd2: begin op = OP_CFGCVIF; pl = cvif_pl;     end
              4'd3: begin op = OP_CVAIF;   pl = desc.ifaddr; end
              4'd4: begin op = OP_CVAW;    pl = desc.weaddr; end
              4'd5: begin op = OP_CVAOF;   pl = desc.ofaddr; end
`ifdef INSN_ENC_SELPE_EN
              // Broadcast to every PE: peid field left at 0.
              4'd6: begin op = OP_CVSELPE; pl = 27'(1) << SELPE_BCAST_BIT; end
              4'd7: op = OP_CVLIFP;
              4'd8: op = OP_CVLWP;
              4'd9: op = OP_CVSOFP;
`else
              4'd6: op = OP_CVLIFP;
              4'd7: op = OP_CVLWP;
              4'd8: op = OP_CVSOFP;
`endif
              default: ;
            endcase
          end
          LAYER_MP: begin
            case (idx)
              4'd1: begin op = OP_MPAIF; pl = desc.ifaddr; end
              4'd2: begin op = OP_MPSOF; pl = desc.ofaddr; end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end else if (desc.last && (idx == n_layer)) begin
      op = OP_EOC;
    end
  end

  assign word    = mk_word(op, pl);
  assign empty   = (n_total == 5'd0);
  assign is_last = !empty && ({1'b0, idx} == (n_total - 5'd1));

endmodule

// File: rtl/insn_encoder.sv
// Expands layer descriptors into the instruction word stream and writes it to instruction RAM.
// Optional CVSELPE emission is enabled with INSN_ENC_SELPE_EN (handled in insn_word_rom).
module insn_encoder
  import insn_enc_pkg::*;
#(
  parameter int AW = 13
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          desc_valid,
  output logic          desc_ready,
  input  logic [4:0]    desc_type,
  input  logic [4:0]    desc_act,
  input  logic          desc_bias,
  input  logic          desc_last,
  input  logic [10:0]   desc_cin,
  input  logic [10:0]   desc_cout,
  input  logic [4:0]    desc_k,
  input  logic [12:0]   desc_h,
  input  logic [12:0]   desc_w,
  input  logic [26:0]   desc_ifaddr,
  input  logic [26:0]   desc_weaddr,
  input  logic [26:0]   desc_ofaddr,
  output logic          iw_en,
  input  logic          iw_ready,
  output logic [AW-1:0] iw_addr,
  output logic [31:0]   iw_data,
  output logic          done,
  output logic          err
);

  typedef enum logic [1:0] {S_IDLE, S_EMIT, S_DONE, S_ERR} state_t;

  localparam logic [AW-1:0] ADDR_MAX = {AW{1'b1}};

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          is_last_q, is_last_d;
  logic          err_q, err_d;
  desc_t         desc_q, desc_d;

  desc_t         desc_in;
  desc_t         rom_desc;
  logic [3:0]    rom_idx;
  logic [31:0]   rom_word;
  logic          rom_last;
  logic          rom_empty;

  assign desc_in = '{typ: desc_type, act: desc_act, bias: desc_bias, last: desc_last,
                     cin: desc_cin, cout: desc_cout, k: desc_k, h: desc_h, w: desc_w,
                     ifaddr: desc_ifaddr, weaddr: desc_weaddr, ofaddr: desc_ofaddr};

  // The ROM looks one word ahead so iw_data can be registered: word 0 of the
  // incoming descriptor while idle, the following word of the latched one while emitting.
  always_comb begin
    rom_desc = desc_q;
    rom_idx  = idx_q + 4'd1;
    if (state_q == S_IDLE) begin
      rom_desc = desc_in;
      rom_idx  = 4'd0;
    end
  end

  insn_word_rom u_rom (
    .desc_i  (rom_desc),
    .idx     (rom_idx),
    .word    (rom_word),
    .is_last (rom_last),
    .empty   (rom_empty)
  );

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    data_d    = data_q;
    is_last_d = is_last_q;
    err_d     = err_q;
    desc_d    = desc_q;
    if (clr) begin
      state_d   = S_IDLE;
      idx_d     = '0;
      addr_d    = '0;
      data_d    = '0;
      is_last_d = 1'b0;
      err_d     = 1'b0;
      desc_d    = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (desc_valid) begin
            desc_d = desc_in;
            idx_d  = '0;
            if (layer_words(desc_in.typ) == 4'd0) begin
              err_d = 1'b1;
            end
            if (!rom_empty) begin
              data_d    = rom_word;
              is_last_d = rom_last;
              state_d   = S_EMIT;
            end
          end
        end
        S_EMIT: begin
          if (iw_ready) begin
            if (is_last_q) begin
              state_d = desc_q.last ? S_DONE : S_IDLE;
              if (addr_q != ADDR_MAX) begin
                addr_d = addr_q + 1'b1;
              end
            end else if (addr_q == ADDR_MAX) begin
              // Words remain but the RAM is full: stop rather than wrap.
              state_d = S_ERR;
              err_d   = 1'b1;
            end else begin
              addr_d    = addr_q + 1'b1;
              idx_d     = idx_q + 4'd1;
              data_d    = rom_word;
              is_last_d = rom_last;
            end
          end
        end
        S_DONE: ;
        S_ERR:  ;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      is_last_q <= 1'b0;
      err_q     <= 1'b0;
      desc_q    <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      is_last_q <= is_last_d;
      err_q     <= err_d;
      desc_q    <= desc_d;
    end
  end

  assign iw_en      = (state_q == S_EMIT);
  assign desc_ready = (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;
  assign iw_addr    = addr_q;
  assign iw_data    = data_q;

endmodule
